// File: rtl/para_regfile.sv
// para_regfile: 2-read/1-write register file, r0 hardwired to zero, optional write-through bypass
module para_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int NREGS = 2 ** ADDR_WIDTH;
    logic [NREGS-1:0]      wen;
    logic [DATA_WIDTH-1:0] regs [NREGS-1:1];
    always_comb begin
        wen = '0;
        for (int k = 1; k < NREGS; k++)
            wen[k] = write_enable & (write_addr == ADDR_WIDTH'(k)) & ~rst;
    end
    always_ff @(posedge clk) begin
        for (int k = 1; k < NREGS; k++)
            if (rst) regs[k] <= '0;
            else if (wen[k]) regs[k] <= write_data;
    end
    always_comb begin
        read_data1 = (read_addr1 == '0) ? '0 :
                     ((BYPASS != 0) && wen[read_addr1]) ? write_data : regs[read_addr1];
        read_data2 = (read_addr2 == '0) ? '0 :
                     ((BYPASS != 0) && wen[read_addr2]) ? write_data : regs[read_addr2];
    end
endmodule

// File: tb/tb_para_regfile.sv
// tb_para_regfile: scoreboard bench driving a write-back and a write-through instance in lockstep
module tb_para_regfile;
    logic        clk = 1'b0;
    logic        rst, write_enable;
    logic [4:0]  write_addr, read_addr1, read_addr2;
    logic [31:0] write_data, rd1_a, rd2_a, rd1_b, rd2_b;
    int          total = 0, bad = 0;
    logic [31:0] mdl [32];
    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    para_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(rd1_a), .read_data2(rd2_a)
    );
    para_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && write_enable && !rst && write_addr == a) return write_data;
        return mdl[a];
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'h1, 32'h0);
            return;
        end
        e = exp_q.pop_front();
        check(e.tag, got, e.v);
    endtask

    task automatic tick;
        @(posedge clk);
        if (rst) foreach (mdl[k]) mdl[k] = 32'h0;
        else if (write_enable && write_addr != 5'd0) mdl[write_addr] = write_data;
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        read_addr1 = a1;
        read_addr2 = a2;
        push({tag, ".b0.r1"}, model_rd(a1, 1'b0));
        push({tag, ".b0.r2"}, model_rd(a2, 1'b0));
        push({tag, ".b1.r1"}, model_rd(a1, 1'b1));
        push({tag, ".b1.r2"}, model_rd(a2, 1'b1));
        #1;
        pop_check(rd1_a);
        pop_check(rd2_a);
        pop_check(rd1_b);
        pop_check(rd2_b);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) rd("reset_sweep", 5'(a), 5'(31 - a));

        wr(5'd8, 32'hDEADBEEF);
        rd("basic_r8_r7", 5'd8, 5'd7);
        check("basic_r8_const", rd1_a, 32'hDEADBEEF);
        rd("basic_r9_r8", 5'd9, 5'd8);

        write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
        rd("zero_same_cycle", 5'd0, 5'd0);
        tick();
        write_enable = 1'b0;
        rd("zero_after", 5'd0, 5'd0);
        check("zero_const", rd2_b, 32'h0);

        wr(5'd5, 32'h11111111);
        write_enable = 1'b1; write_addr = 5'd5; write_data = 32'h22222222;
        rd("same_cycle_r5", 5'd5, 5'd5);
        check("same_cycle_b0_const", rd2_a, 32'h11111111);
        check("same_cycle_b1_const", rd2_b, 32'h22222222);
        tick();
        write_enable = 1'b0;
        rd("after_edge_r5", 5'd5, 5'd5);

        wr(5'd3, 32'h0000ABCD);
        rst = 1'b1; write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h12345678;
        rd("collision_pre", 5'd3, 5'd3);
        check("collision_b1_const", rd1_b, 32'h0000ABCD);
        tick();
        rst = 1'b0; write_enable = 1'b0;
        rd("collision_r3", 5'd3, 5'd3);
        check("collision_r3_const", rd1_a, 32'h0);
        for (int a = 0; a < 32; a++) rd("midreset_sweep", 5'(a), 5'(a));

        for (int k = 1; k < 32; k++) wr(5'(k), 32'(k) * 32'h01010101);
        for (int k = 0; k < 32; k++) rd("dual_port", 5'(k), 5'(31 - k));
        check("dual_r31_const", rd1_a, 32'h1F1F1F1F);

        write_enable = 1'b0; write_addr = 5'd10; write_data = 32'h00000BAD;
        tick();
        rd("we_gate_r10", 5'd10, 5'd10);
        check("we_gate_const", rd1_a, 32'h0A0A0A0A);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/para_regfile.md
Name: para_regfile

Overview:
- Parameterised register file for the single-cycle MIPS datapath, with two read ports and one write port.
- The write port decodes the write address into a one-hot enable that steers write_data to exactly one register, which is the demultiplex direction of the datapath's 2:1 muxes.
- It sits between the write-back mux (the RegDst/MemtoReg selection) and the ALU operand inputs.

Parameters:
- DATA_WIDTH, 32: width of each register and data port.
- ADDR_WIDTH, 5: register address width; the file holds 2**ADDR_WIDTH registers.
- BYPASS, 0: when 1, a read of the address being written this cycle returns write_data (write-through); when 0, it returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- write_enable  input  1  RegWrite from the control unit.
- write_addr  input  ADDR_WIDTH  destination register.
- write_data  input  DATA_WIDTH  value to write.
- read_addr1  input  ADDR_WIDTH  rs address.
- read_addr2  input  ADDR_WIDTH  rt address.
- read_data1  output  DATA_WIDTH  contents of read_addr1.
- read_data2  output  DATA_WIDTH  contents of read_addr2.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Storage:
  - 2**ADDR_WIDTH registers of DATA_WIDTH bits.
  - Register 0 is hardwired to zero: never stored, always reads 0.
- Write decode:
  - Combinational one-hot enable vector, bit k = write_enable & (write_addr == k) & !rst, for k = 1 .. 2**ADDR_WIDTH-1.
  - Bit 0 is constant 0.
- Write timing:
  - On a rising clk edge with enable bit k set, register k <= write_data.
  - The new value is visible on the read ports from the following cycle (1-cycle write latency).
  - All other registers hold their value.
- Reset:
  - On a rising clk edge with rst=1, all registers <= 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset asserted mid-program clears the whole file on that edge.
  - Before the first reset edge, register contents are undefined; the bench must not check them.
- Reads:
  - Purely combinational (0-cycle latency) from read_addr to read_data.
  - Both ports are independent and may address the same register.
  - read_data for address 0 is always 0.
- Read/write same address in the same cycle:
  - BYPASS=0: read returns the old stored value until the edge.
  - BYPASS=1: read returns write_data when write_enable=1, rst=0, address matches and address != 0; otherwise the stored value.
- Output reset values: there is no output register. After a reset edge, both read ports return 0 for every address until a subsequent write.
- Write to address 0: accepted on the bus with no effect; no error flag.
- Width rules:
  - Addresses are compared as unsigned.
  - No truncation or sign extension inside the block.

Test Plan:
1. Reset then read all: rst=1 for 1 edge, then sweep read_addr1/2 over 0..31 -> every read_data = 0x00000000.
2. Basic write/read: write 0xDEADBEEF to r8 with write_enable=1 for one edge -> read_data1 (addr 8) = 0xDEADBEEF on the next cycle; r7 and r9 still 0.
3. $zero protection: write 0xFFFFFFFF to r0 -> read_data1/2 at addr 0 stay 0x00000000.
4. Same-cycle read/write on r5 (holding 0x11111111), writing 0x22222222:
   - BYPASS=0 -> read_data2 = 0x11111111 before the edge, 0x22222222 after.
   - BYPASS=1 -> 0x22222222 in the same cycle.
5. Reset vs write collision: r3 = 0x0000ABCD; assert rst and write_enable to r3 with 0x12345678 on the same edge -> r3 = 0 afterwards, and 0x12345678 never appears.
6. Dual-port independence and write_enable gating: fill r1..r31 with value k*0x01010101 -> read_addr1=k and read_addr2=31-k return the matching pair for all k. A write with write_enable=0 changes nothing.
